mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one data-memory port between N generated procedure engines.
- Each engine uses the addr/size/valid/write/wdata/rdata/ready load-store handshake: it holds valid until it sees ready, then drops valid on the next cycle.
- The block sits between the engines and the single memory or bus slave. It serializes their accesses with fair rotation and a per-transaction timeout that aborts hung accesses and reports them.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between N requesters,
// with a per-transaction timeout that aborts hung accesses.
// Ports:
//   clk, rstb        clock, synchronous active-low reset
//   req_valid/write  per-requester request and direction
//   req_addr/size    flattened per-requester address and size code
//   req_wdata        flattened per-requester store data
//   req_ready        per-requester completion strobe (combinational)
//   req_rdata        shared load data (0 on a timeout)
//   mem_*            registered request to the single memory slave
//   mem_rdata/ready  memory response
//   grant            one-hot owner of the current transaction
//   busy             transaction in flight
//   err, err_clr     sticky per-requester timeout flags and their clear
module mem_port_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*3-1:0]  req_size,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [DW-1:0]   req_rdata,
  output logic            mem_valid,
  output logic            mem_write,
  output logic [AW-1:0]   mem_addr,
  output logic [2:0]      mem_size,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic [N-1:0]    err,
  input  logic [N-1:0]    err_clr
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] own_q, own_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mv_q, mv_d;
  logic          mw_q, mw_d;
  logic [AW-1:0] ma_q, ma_d;
  logic [2:0]    ms_q, ms_d;
  logic [DW-1:0] md_q, md_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  err_q, err_d;

  logic [PW-1:0] pick;
  logic          found;
  logic          tmo;
  logic          done;
  int            idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // mem_ready on the last allowed cycle beats the timeout.
  assign tmo = (TIMEOUT != 0) && (state_q == BUSY) &&
               (timer_q == TMO_LAST) && !mem_ready;
  assign done = mv_q && (mem_ready || tmo);

  assign req_ready = done ? grant_q : '0;
  assign req_rdata = tmo ? '0 : mem_rdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    timer_d = timer_q;
    mv_d    = mv_q;
    mw_d    = mw_q;
    ma_d    = ma_q;
    ms_d    = ms_q;
    md_d    = md_q;
    grant_d = grant_q;
    // A timeout setting a bit wins over a same-edge clear.
    err_d   = (err_q & ~err_clr) | (tmo ? grant_q : '0);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          mv_d    = 1'b1;
          mw_d    = req_write[pick];
          ma_d    = req_addr[pick*AW +: AW];
          ms_d    = req_size[pick*3 +: 3];
          md_d    = req_wdata[pick*DW +: DW];
          grant_d = N'(1) << pick;
          own_d   = pick;
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          mv_d    = 1'b0;
          grant_d = '0;
          ptr_d   = (own_q == PW'(N-1)) ? '0 : own_q + PW'(1);
          state_d = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      timer_q <= '0;
      mv_q    <= 1'b0;
      mw_q    <= 1'b0;
      ma_q    <= '0;
      ms_q    <= '0;
      md_q    <= '0;
      grant_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      timer_q <= timer_d;
      mv_q    <= mv_d;
      mw_q    <= mw_d;
      ma_q    <= ma_d;
      ms_q    <= ms_d;
      md_q    <= md_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign mem_valid = mv_q;
  assign mem_write = mw_q;
  assign mem_addr  = ma_q;
  assign mem_size  = ms_q;
  assign mem_wdata = md_q;
  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus
// hand-written fairness, wrap, err_clr and mid-transaction reset runs.
module tb_mem_port_arbiter;

  logic         clk;
  logic         rstb;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [11:0]  req_size;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [31:0]  req_rdata;
  logic         mem_valid;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [2:0]   mem_size;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic [3:0]   grant;
  logic         busy;
  logic [3:0]   err;
  logic [3:0]   err_clr;

  mem_port_arbiter #(
    .N(4), .AW(32), .DW(32), .TIMEOUT(4), .TW(8)
  ) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .req_rdata(req_rdata), .mem_valid(mem_valid),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ready in BUSY cycle 'lat' (1-based); lat=0 never.
  int          lat = 0;
  int          bcnt = 1;
  logic [31:0] mem_data = '0;

  always @(posedge clk) begin
    if (!mem_valid) bcnt <= 1;
    else bcnt <= bcnt + 1;
  end

  assign mem_ready = mem_valid && (lat != 0) && (bcnt == lat);
  assign mem_rdata = mem_data;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrd;
    logic [31:0] erd;
    logic [3:0]  eerr;
    int          elat;
  } vec_t;

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vt[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion strobe must match the next expectation.
  always @(negedge clk) begin
    if (rstb && req_ready != 4'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready actual=%b required=none", req_ready);
      end else begin
        mon_e = sbq.pop_front();
        chk("ready_port", 64'(req_ready), 64'(mon_e.rdy));
        chk("ready_rdata", 64'(req_rdata), 64'(mon_e.rd));
        chk("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int p, logic wr, logic [31:0] a,
                       logic [2:0] s, logic [31:0] wd);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p*32 +: 32] = a;
    req_size[p*3 +: 3] = s;
    req_wdata[p*32 +: 32] = wd;
  endtask

  task automatic reset_dut();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    bit         seen;
    logic [3:0] oh;
    oh = 4'(1 << v.port);
    mem_data = v.mrd;
    lat = v.lat;
    drive(v.port, v.wr, v.addr, v.size, v.wdata);
    sbq.push_back('{oh, v.erd, cyc + v.elat});
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      chk("busy_mem_valid", 64'(mem_valid), 64'(1));
      chk("busy_grant", 64'(grant), 64'(oh));
      chk("busy_mem_addr", 64'(mem_addr), 64'(v.addr));
      chk("busy_mem_write", 64'(mem_write), 64'(v.wr));
      chk("busy_mem_size", 64'(mem_size), 64'(v.size));
      chk("busy_mem_wdata", 64'(mem_wdata), 64'(v.wdata));
      if (req_ready[v.port]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL no_ready actual=none required=port%0d", v.port);
    end
    tick();
    req_valid[v.port] = 1'b0;
    chk("err_after", 64'(err), 64'(v.eerr));
    chk("idle_after", 64'({mem_valid, busy, grant}), 64'(0));
  endtask

  initial begin
    vt[0] = '{1, 1'b0, 32'h40, 3'd2, 32'h0,
              3, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 3};
    vt[1] = '{3, 1'b1, 32'h1C, 3'd2, 32'h12345678,
              2, 32'h0, 32'h0, 4'b0000, 2};
    vt[2] = '{0, 1'b0, 32'h100, 3'd2, 32'h0,
              0, 32'hCAFE, 32'h0, 4'b0001, 4};
    vt[3] = '{2, 1'b0, 32'h8, 3'd2, 32'h0,
              4, 32'hA5, 32'hA5, 4'b0001, 4};
    vt[4] = '{1, 1'b0, 32'h41, 3'd0, 32'h0,
              1, 32'h77, 32'h77, 4'b0001, 1};
    vt[5] = '{2, 1'b1, 32'h200, 3'd1, 32'hBEEF,
              5, 32'h99, 32'h0, 4'b0101, 4};
    vt[6] = '{2, 1'b0, 32'h300, 3'd2, 32'h0,
              1, 32'h33, 32'h33, 4'b0100, 1};

    rstb = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_size = '0;
    req_wdata = '0;
    err_clr = '0;
    tick();
    tick();
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_mem_write", 64'(mem_write), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_size", 64'(mem_size), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    rstb = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    err_clr = 4'b0001;
    tick();
    err_clr = '0;
    chk("err_clr", 64'(err), 64'(4'b0100));

    // ptr=3 here: ports 0 and 1 must be served 0 then 1.
    mem_data = 32'h22;
    lat = 1;
    drive(0, 1'b0, 32'h10, 3'd2, 32'h0);
    drive(1, 1'b0, 32'h14, 3'd2, 32'h0);
    sbq.push_back('{4'b0001, 32'h22, cyc + 1});
    sbq.push_back('{4'b0010, 32'h22, cyc + 3});
    tick();
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    req_valid[1] = 1'b0;
    tick();
    chk("wrap_drained", 64'(sbq.size()), 64'(0));

    run_vec(vt[6]);

    // ptr=3: grant port 0, reset mid-transaction, then ptr must be 0.
    lat = 0;
    drive(0, 1'b0, 32'h50, 3'd2, 32'h0);
    tick();
    chk("mrst_grant0", 64'(grant), 64'(4'b0001));
    drive(2, 1'b0, 32'h58, 3'd2, 32'h0);
    drive(3, 1'b0, 32'h5C, 3'd2, 32'h0);
    tick();
    chk("mrst_still0", 64'(grant), 64'(4'b0001));
    rstb = 1'b0;
    tick();
    chk("mrst_mem_valid", 64'(mem_valid), 64'(0));
    chk("mrst_grant", 64'(grant), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_err", 64'(err), 64'(0));
    rstb = 1'b1;
    req_valid[0] = 1'b0;
    lat = 2;
    mem_data = 32'h44;
    tick();
    chk("mrst_grant2", 64'(grant), 64'(4'b0100));
    sbq.push_back('{4'b0100, 32'h44, cyc + 1});
    tick();
    tick();
    req_valid = '0;
    tick();
    chk("mrst_drained", 64'(sbq.size()), 64'(0));
    chk("mrst_idle", 64'(busy), 64'(0));

    // Fairness: all ports held, zero-wait memory.
    reset_dut();
    tick();
    lat = 1;
    mem_data = 32'h11;
    for (int p = 0; p < 4; p++)
      drive(p, 1'b0, 32'(p * 4), 3'd2, 32'h0);
    for (int i = 0; i < 5; i++)
      sbq.push_back('{4'(1 << (i % 4)), 32'h11, cyc + 1 + 2 * i});
    repeat (10) tick();
    req_valid = '0;
    tick();
    tick();
    chk("fair_drained", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
